btn_conditioner: RTL

Conditions the five raw push-button inputs before they reach the `cpu` top-level `btn[4:0]` port. Each button passes through:
- a two-flop synchronizer;
- a per-button stability-counter debouncer;
- a rising-edge (press) pulse generator.

Presses are collected in a sticky pending register that the CPU side clears by acknowledge mask, with a combined interrupt line.

---
 rtl/btn_conditioner.sv | 56 +++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects raw push buttons,
// latching presses into ack-clearable pending flags with a combined irq.
module btn_conditioner #(
  parameter int NBTN            = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [NBTN-1:0] evt_ack,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] evt_pending,
  output logic            irq
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [NBTN-1:0]  s1_q, s2_q, lvl_q, lvl_d, press_q, press_d, pend_q, pend_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  // any sample matching the current level restarts that button's count
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = (s2_q[i] == lvl_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
      if (s2_q[i] != lvl_q[i] && cnt_q[i] == CNT_MAX) lvl_d[i] = s2_q[i];
    end
    press_d = lvl_d & ~lvl_q;
    pend_d  = (pend_q & ~evt_ack) | press_d;
    irq_d   = |pend_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign btn_level   = lvl_q;
  assign btn_press   = press_q;
  assign evt_pending = pend_q;
  assign irq         = irq_q;
endmodule
